// File: rtl/dart_pkg.sv
// dart_pkg: shared definitions for the darts match controller.
//   state_t    - controller state encoding
//   GRID       - side length of the square dart sensor grid
//   POINT_*    - point value awarded for each ring, plus the miss value
package dart_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT_DART,
        ST_LOOKUP,
        ST_APPLY,
        ST_TURN_DONE,
        ST_RESULT,
        ST_FINISH
    } state_t;

    localparam int GRID = 10;

    localparam logic [5:0] POINT_R1   = 6'd50;
    localparam logic [5:0] POINT_R3   = 6'd25;
    localparam logic [5:0] POINT_R5   = 6'd20;
    localparam logic [5:0] POINT_R7   = 6'd10;
    localparam logic [5:0] POINT_R9   = 6'd5;
    localparam logic [5:0] POINT_MISS = 6'd0;

endpackage

// File: rtl/dart_match_point_lut.sv
// dart_point_lut: combinational point map for one dart.
//   x, y  : grid column/row; 10..15 on either axis is a miss
//   point : ring value (50/25/20/10/5) or 0 for a miss
// Rings are concentric squares around the board centre at 4.5, so working in
// doubled coordinates keeps the distance |2x-9| an odd integer 1..9.
module dart_point_lut
    import dart_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [5:0] point
);

    logic [4:0] x2;
    logic [4:0] y2;
    logic [4:0] dx;
    logic [4:0] dy;
    logic [4:0] r;

    // Chebyshev distance from the centre selects the ring.
    always_comb begin
        x2    = {x, 1'b0};
        y2    = {y, 1'b0};
        dx    = (x2 > 5'd9) ? (x2 - 5'd9) : (5'd9 - x2);
        dy    = (y2 > 5'd9) ? (y2 - 5'd9) : (5'd9 - y2);
        r     = (dx > dy) ? dx : dy;
        point = POINT_MISS;
        if ((x < 4'(GRID)) && (y < 4'(GRID))) begin
            case (r)
                5'd1:    point = POINT_R1;
                5'd3:    point = POINT_R3;
                5'd5:    point = POINT_R5;
                5'd7:    point = POINT_R7;
                5'd9:    point = POINT_R9;
                default: point = POINT_MISS;
            endcase
        end
    end

endmodule

// File: rtl/dart_match.sv
// dart_match: N-player darts match controller with bust and exact-zero rules.
//   clk, reset             - clock, asynchronous active-high reset
//   dart_come_i            - dart strobe, taken only while dart_ready_o=1
//   dart_position_x_i/y_i  - grid position of the dart (10..15 = miss)
//   new_game_i             - restart request, taken only after a win
//   score_sel_i            - player index for score_o readout
//   dart_ready_o           - waiting for a dart
//   current_player_o       - player currently throwing
//   player_done_o          - one-hot pulse at the end of a player's turn
//   bust_o                 - pulse with player_done_o when the turn busted
//   game_set_o             - pulse when a player reaches exactly zero
//   winner_valid_o/id_o    - winner, held until the next game starts
//   score_o                - score of player score_sel_i (0 if out of range)
module dart_match
    import dart_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int START_SCORE    = 501,
    parameter int SCORE_W        = 9,
    parameter int DARTS_PER_TURN = 3,
    parameter int PID_W          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dart_come_i,
    input  logic [3:0]             dart_position_x_i,
    input  logic [3:0]             dart_position_y_i,
    input  logic                   new_game_i,
    input  logic [PID_W-1:0]       score_sel_i,
    output logic                   dart_ready_o,
    output logic [PID_W-1:0]       current_player_o,
    output logic [NUM_PLAYERS-1:0] player_done_o,
    output logic                   bust_o,
    output logic                   game_set_o,
    output logic                   winner_valid_o,
    output logic [PID_W-1:0]       winner_id_o,
    output logic [SCORE_W-1:0]     score_o
);

    state_t             state;
    state_t             state_next;
    logic [SCORE_W-1:0] scores [NUM_PLAYERS];
    logic [SCORE_W-1:0] turn_start;
    logic [SCORE_W-1:0] cur_score;
    logic [SCORE_W-1:0] point_ext;
    logic [PID_W-1:0]   cur_player;
    logic [PID_W-1:0]   next_player;
    logic [PID_W-1:0]   winner_id;
    logic               winner_valid;
    logic [2:0]         dart_cnt;
    logic [2:0]         dart_cnt_inc;
    logic [3:0]         x_reg;
    logic [3:0]         y_reg;
    logic [5:0]         lut_point;
    logic [5:0]         point_reg;
    logic               bust_flag;

    dart_point_lut u_lut (
        .x     (x_reg),
        .y     (y_reg),
        .point (lut_point)
    );

    assign cur_score        = scores[cur_player];
    assign point_ext        = SCORE_W'(point_reg);
    assign dart_cnt_inc     = dart_cnt + 3'd1;
    assign next_player      = (cur_player == PID_W'(NUM_PLAYERS - 1)) ? '0 : cur_player + 1'b1;
    assign current_player_o = cur_player;
    assign winner_valid_o   = winner_valid;
    assign winner_id_o      = winner_id;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and pulse outputs. Exact zero is tested before the bust and
    // dart-count checks so a finishing dart always wins the game.
    always_comb begin
        state_next    = state;
        dart_ready_o  = 1'b0;
        player_done_o = '0;
        bust_o        = 1'b0;
        game_set_o    = 1'b0;
        case (state)
            ST_INIT: state_next = ST_WAIT_DART;
            ST_WAIT_DART: begin
                dart_ready_o = 1'b1;
                if (dart_come_i) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: state_next = ST_APPLY;
            ST_APPLY: begin
                if (point_ext == cur_score)                    state_next = ST_RESULT;
                else if (point_ext > cur_score)                state_next = ST_TURN_DONE;
                else if (dart_cnt_inc == 3'(DARTS_PER_TURN))   state_next = ST_TURN_DONE;
                else                                           state_next = ST_WAIT_DART;
            end
            ST_TURN_DONE: begin
                player_done_o = NUM_PLAYERS'(1) << cur_player;
                bust_o        = bust_flag;
                state_next    = ST_WAIT_DART;
            end
            ST_RESULT: begin
                game_set_o = 1'b1;
                state_next = ST_FINISH;
            end
            ST_FINISH: begin
                if (new_game_i) state_next = ST_INIT;
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Game datapath. A bust rolls the player back to the score snapshotted
    // when the turn started; the compare precedes the subtract so no underflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) scores[p] <= '0;
            turn_start   <= '0;
            cur_player   <= '0;
            dart_cnt     <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            point_reg    <= '0;
            bust_flag    <= 1'b0;
            winner_id    <= '0;
            winner_valid <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    for (int p = 0; p < NUM_PLAYERS; p++) scores[p] <= SCORE_W'(START_SCORE);
                    turn_start   <= SCORE_W'(START_SCORE);
                    cur_player   <= '0;
                    dart_cnt     <= '0;
                    bust_flag    <= 1'b0;
                    winner_valid <= 1'b0;
                end
                ST_WAIT_DART: begin
                    if (dart_come_i) begin
                        x_reg <= dart_position_x_i;
                        y_reg <= dart_position_y_i;
                    end
                end
                ST_LOOKUP: point_reg <= lut_point;
                ST_APPLY: begin
                    if (point_ext == cur_score) begin
                        scores[cur_player] <= '0;
                    end else if (point_ext > cur_score) begin
                        scores[cur_player] <= turn_start;
                        bust_flag          <= 1'b1;
                    end else begin
                        scores[cur_player] <= cur_score - point_ext;
                        dart_cnt           <= dart_cnt_inc;
                    end
                end
                ST_TURN_DONE: begin
                    cur_player <= next_player;
                    dart_cnt   <= '0;
                    turn_start <= scores[next_player];
                    bust_flag  <= 1'b0;
                end
                ST_RESULT: begin
                    winner_id    <= cur_player;
                    winner_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Score readout; indices beyond the last player read as zero.
    always_comb begin
        score_o = '0;
        if (int'(score_sel_i) < NUM_PLAYERS) score_o = scores[score_sel_i];
    end

endmodule

// File: doc/dart_match.md
Name: dart_match

Overview:
- Parametrised darts match controller. Scores N players in rotation, with up to DARTS_PER_TURN darts per turn and bust/exact-zero rules.
- Sits between the dart sensor front end (the valid strobe plus a 10x10 grid position) and the score display / test pattern.
- Successor to the fixed two-player, one-dart-per-turn scorer. Adds:
  - player count, start score and darts per turn as parameters
  - bust handling
  - a positional point map
  - per-player score readout
  - restart without reset

Parameters:
- NUM_PLAYERS, 2, number of players in rotation (2..8).
- START_SCORE, 501, score loaded into every player at game start.
- SCORE_W, 9, score register width; must satisfy START_SCORE < 2**SCORE_W.
- DARTS_PER_TURN, 3, maximum darts per turn (1..7).
- PID_W, $clog2(NUM_PLAYERS) with a minimum of 1, width of player index fields.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- dart_come_i  in  1  dart strobe; honoured only while dart_ready_o=1.
- dart_position_x_i  in  4  column 0..9; values 10..15 are a miss.
- dart_position_y_i  in  4  row 0..9; values 10..15 are a miss.
- new_game_i  in  1  restart request; honoured only in FINISH.
- score_sel_i  in  PID_W  player index for the score readout.
- dart_ready_o  out  1  block is waiting for a dart.
- current_player_o  out  PID_W  index of the player throwing.
- player_done_o  out  NUM_PLAYERS  one-hot, 1-cycle pulse at end of that player's turn.
- bust_o  out  1  1-cycle pulse, coincident with player_done_o, when the turn busted.
- game_set_o  out  1  1-cycle pulse when a player reaches 0.
- winner_valid_o  out  1  high from RESULT until the next INIT.
- winner_id_o  out  PID_W  index of the winning player; valid when winner_valid_o=1.
- score_o  out  SCORE_W  score of player score_sel_i, combinational mux; an index >= NUM_PLAYERS reads 0.

Behaviour:
- Reset values:
  - every output is 0; all scores are 0; current player is 0; dart count is 0.
  - state is INIT.
- States and transitions:
  - INIT: load START_SCORE into every player; clear winner_valid_o, current player and dart count. Next state WAIT_DART.
  - WAIT_DART: dart_ready_o=1. When dart_come_i=1, capture x/y into registers and go to LOOKUP; otherwise stay.
  - LOOKUP: register the point value from dart_point_lut. Go to APPLY.
  - APPLY, with P = point and S = score of the current player:
    - P == S: S <= 0; go to RESULT.
    - P > S: bust. Restore S to the turn-start snapshot and go to TURN_DONE with the bust flag set.
    - P < S: S <= S - P and increment the dart count. Go to TURN_DONE if the count reaches DARTS_PER_TURN, else WAIT_DART.
  - TURN_DONE:
    - player_done_o[current] = 1; bust_o = bust flag.
    - Advance current player; NUM_PLAYERS-1 wraps to 0.
    - Clear the dart count; snapshot the next player's score as its turn-start value.
    - Go to WAIT_DART.
  - RESULT: game_set_o=1; winner_id_o <= current player; winner_valid_o <= 1. Go to FINISH.
  - FINISH: hold all state; new_game_i=1 goes to INIT. dart_come_i is ignored.
- Latency: a dart accepted in cycle t has its score updated at the end of cycle t+2; player_done_o or game_set_o is high in cycle t+3.
- Point map (combinational, on the registered x/y):
  - dx = |2x-9|, dy = |2y-9|, r = max(dx,dy).
  - r=1 -> 50; r=3 -> 25; r=5 -> 20; r=7 -> 10; r=9 -> 5.
  - Out-of-range x or y -> 0. A miss still counts as a dart.
- Arithmetic:
  - P is zero-extended to SCORE_W.
  - The compare is done before the subtract, so a score never underflows.
  - A zero-point dart leaves S unchanged.
- Boundary and ordering rules:
  - dart_come_i outside WAIT_DART, or while held high, is not queued; each WAIT_DART visit accepts exactly one dart.
  - new_game_i outside FINISH is ignored.
  - reset asserted in any state forces reset values immediately (asynchronously); the game restarts from INIT after reset release.
  - The exact-zero check takes priority over the dart-count limit.

Decomposition:
- Package dart_pkg holds:
  - the state enum
  - ring point constants (50/25/20/10/5)
  - GRID=10
  - the miss value 0
- Sub-module dart_point_lut: 4-bit x and 4-bit y in, 6-bit point out, combinational.

Test Plan:
- Reset/INIT: assert reset mid-stream, release it -> every output is 0 during reset. dart_ready_o=1 two cycles after release, and score_o=501 for both players.
- Full turn, defaults: player 0 throws (4,4), (0,0), (2,5) -> each dart is accepted only while dart_ready_o=1. Scores 451, 446, 426; player_done_o=2'b01 pulse; current_player_o=1.
- Bust, START_SCORE=60: player 0 throws (4,4) then (3,3) -> score 10 after the first dart. The second dart is 25 > 10, so the score is restored to 60, bust_o and player_done_o[0] pulse together, and the turn ends after 2 darts.
- Win, START_SCORE=60: player 0 throws (4,4) then (1,4) -> score 0, game_set_o pulses once, winner_valid_o=1 and winner_id_o=0. Later strobes are ignored; new_game_i reloads 60.
- Rotation, NUM_PLAYERS=3, DARTS_PER_TURN=1, (15,15) misses -> player_done_o pulses 001, 010, 100, 001, showing the 2->0 wrap. All scores stay 501.
- Strobe discipline and async reset: hold dart_come_i high for 5 cycles -> exactly one dart is consumed per WAIT_DART visit. Then assert reset during APPLY -> outputs clear in the same cycle without a clock edge, and the half-applied dart is lost.
